// File: rtl/pipeline_mem_responder_if.sv
// pipeline_mem_responder_if: processor <-> memory responder bus (fetch port, data port, buffer status)
// master: processor side, drives addresses, store data and requests.
// slave:  memory side, returns instr/data_in and mem_stall, wbuf_count, overflow_err.
interface pipeline_mem_responder_if #(
    parameter int WBUF_DEPTH = 4
);
    logic [31:0] inst_addr;
    logic [31:0] instr;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic        mem_stall;
    logic        overflow_err;
    logic [$clog2(WBUF_DEPTH):0] wbuf_count;

    modport master (
        output inst_addr, data_addr, data_out, mem_read, mem_write,
        input  instr, data_in, mem_stall, wbuf_count, overflow_err
    );
    modport slave (
        input  inst_addr, data_addr, data_out, mem_read, mem_write,
        output instr, data_in, mem_stall, wbuf_count, overflow_err
    );
endinterface

// File: rtl/pipeline_mem_responder.sv
// pipeline_mem_responder: unified word memory with posted-write buffer and drain FSM
// Ports: clk, reset (async, active-high), bus (pipeline_mem_responder_if.slave):
//   inst_addr -> instr (fetch), data_addr/data_out/mem_read/mem_write -> data_in (data port),
//   mem_stall (buffer full), wbuf_count (occupancy), overflow_err (sticky dropped store).
// Optional macro IFETCH_BYPASS_EN: instr also sees pending buffered stores.
module pipeline_mem_responder #(
    parameter int ADDR_W       = 10,
    parameter int WBUF_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    pipeline_mem_responder_if.slave bus
);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] bufAddr [WBUF_DEPTH];
    logic [31:0]       bufData [WBUF_DEPTH];
    logic [PW-1:0]     rdPtr, wrPtr;
    logic [CW-1:0]     count, nextCount;
    logic [0:0]        state;
    logic [DW-1:0]     drainCnt;
    logic              ovf, full, pop, push;
    logic [ADDR_W-1:0] dAddr, iAddr;
    logic [31:0]       dWord, iWord;

    assign dAddr     = bus.data_addr[ADDR_W+1:2];
    assign iAddr     = bus.inst_addr[ADDR_W+1:2];
    assign full      = count == CW'(WBUF_DEPTH);
    assign pop       = state == WRITE && drainCnt == '0;
    // a pop in the same cycle frees a slot, so a store while full is still accepted
    assign push      = bus.mem_write && (!full || pop);
    assign nextCount = count + CW'(push) - CW'(pop);

    // walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        dWord = mem[dAddr];
        iWord = mem[iAddr];
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (CW'(i) < count && bufAddr[rdPtr + PW'(i)] == dAddr) dWord = bufData[rdPtr + PW'(i)];
`ifdef IFETCH_BYPASS_EN
            if (CW'(i) < count && bufAddr[rdPtr + PW'(i)] == iAddr) iWord = bufData[rdPtr + PW'(i)];
`endif
        end
    end

    assign bus.data_in      = bus.mem_read ? dWord : '0;
    assign bus.instr        = iWord;
    assign bus.mem_stall    = full;
    assign bus.wbuf_count   = count;
    assign bus.overflow_err = ovf;

    // state is cleared asynchronously, so a reset mid-drain never commits
    always_ff @(posedge clk) begin
        if (pop) mem[bufAddr[rdPtr]] <= bufData[rdPtr];
        if (push) begin
            bufAddr[wrPtr] <= dAddr;
            bufData[wrPtr] <= bus.data_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            state    <= IDLE;
            drainCnt <= '0;
            ovf      <= 1'b0;
        end else begin
            count <= nextCount;
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop) rdPtr <= rdPtr + PW'(1);
            if (bus.mem_write && !push) ovf <= 1'b1;
            if (state == IDLE) begin
                if (count != '0) begin
                    state    <= WRITE;
                    drainCnt <= DW'(DRAIN_CYCLES - 1);
                end
            end else if (drainCnt != '0) begin
                drainCnt <= drainCnt - DW'(1);
            end else begin
                state    <= nextCount != '0 ? WRITE : IDLE;
                drainCnt <= DW'(DRAIN_CYCLES - 1);
            end
        end
    end
endmodule

// File: tb/tb_pipeline_mem_responder.sv
// tb_pipeline_mem_responder: randomized scoreboard bench against a commit-schedule reference model
module tb_pipeline_mem_responder;
    localparam int AW = 6, DEPTH = 4, DC = 4, WORDS = 2**AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_mem_responder_if #(.WBUF_DEPTH(DEPTH)) bus();
    pipeline_mem_responder #(.ADDR_W(AW), .WBUF_DEPTH(DEPTH), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct { logic [AW-1:0] a; logic [31:0] d; } entryT;
    typedef struct { logic [31:0] data, instr; logic [2:0] cnt; logic stall, ovf, chkInstr; } expT;

    int checks = 0, errors = 0;
    logic [31:0] viewMem [WORDS];
    logic [31:0] commitMem [WORDS];
    entryT pend[$];
    expT expQ[$];
    bit schedValid = 0, ovfM = 0, known = 0;
    int sched = 0, edgeN = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            check("data_in", bus.data_in, e.data);
            if (e.chkInstr) check("instr", bus.instr, e.instr);
            check("wbuf_count", 32'(bus.wbuf_count), 32'(e.cnt));
            check("mem_stall", 32'(bus.mem_stall), 32'(e.stall));
            check("overflow_err", 32'(bus.overflow_err), 32'(e.ovf));
        end
    end

    // Reference: commits happen every DC edges once service starts; service starts
    // one edge after the buffer is seen non-empty while idle.
    task automatic modelEdge(bit wr, logic [31:0] addr, logic [31:0] data);
        int pre = pend.size();
        bit pop = schedValid && edgeN == sched;
        bit idleStart = !schedValid && pre > 0;
        if (pop) begin
            commitMem[pend[0].a] = pend[0].d;
            void'(pend.pop_front());
        end
        if (wr && (pre < DEPTH || pop)) begin
            pend.push_back('{addr[AW+1:2], data});
            viewMem[addr[AW+1:2]] = data;
        end else if (wr) ovfM = 1;
        if (pop) schedValid = pend.size() > 0;
        else if (idleStart) schedValid = 1;
        if (pop || idleStart) sched = edgeN + DC;
        edgeN++;
    endtask

    task automatic step(bit wr, bit rd, logic [31:0] addr, logic [31:0] data, logic [31:0] iaddr);
        expT e;
        bus.mem_write = wr;
        bus.mem_read  = rd;
        bus.data_addr = addr;
        bus.data_out  = data;
        bus.inst_addr = iaddr;
        e.data = rd ? viewMem[addr[AW+1:2]] : 32'h0;
`ifdef IFETCH_BYPASS_EN
        e.instr = viewMem[iaddr[AW+1:2]];
`else
        e.instr = commitMem[iaddr[AW+1:2]];
`endif
        e.cnt = 3'(pend.size());
        e.stall = pend.size() == DEPTH;
        e.ovf = ovfM;
        e.chkInstr = known;
        expQ.push_back(e);
        @(posedge clk);
        modelEdge(wr, addr, data);
        #1;
    endtask

    task automatic idle(logic [31:0] iaddr);
        step(0, 0, 32'h0, 32'h0, iaddr);
    endtask

    task automatic drain();
        int g = 0;
        while ((pend.size() > 0 || schedValid) && g < 200) begin
            idle($urandom);
            g++;
        end
        checks++;
        if (g >= 200) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", pend.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.mem_write = 0; bus.mem_read = 0;
        bus.data_addr = 0; bus.data_out = 0; bus.inst_addr = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        for (int a = 0; a < WORDS;) begin
            if (pend.size() < DEPTH) begin
                step(1, 0, 32'(a << 2), $urandom, 32'h0);
                a++;
            end else idle(32'h0);
        end
        drain();
        known = 1;
        // store then load, then committed view after drain
        step(1, 0, 32'h40, 32'hDEADBEEF, 32'h40);
        step(0, 1, 32'h40, 32'h0, 32'h40);
        repeat (DC + 1) idle(32'h40);
        drain();
        // youngest match wins
        step(1, 0, 32'h8, 32'h1, 32'h8);
        step(1, 0, 32'h8, 32'h2, 32'h8);
        step(0, 1, 32'h8, 32'h0, 32'h8);
        drain();
        step(0, 1, 32'h8, 32'h0, 32'h8);
        // same-cycle load and store
        step(1, 0, 32'h10, 32'h5, 32'h0);
        drain();
        step(1, 1, 32'h10, 32'h9, 32'h10);
        step(0, 1, 32'h10, 32'h0, 32'h10);
        drain();
        // fetch of a pending store
        step(1, 0, 32'h20, $urandom, 32'h0);
        step(0, 0, 32'h0, 32'h0, 32'h20);
        drain();
        // fill and overflow
        for (int i = 0; i < 5; i++) step(1, i[0], $urandom, $urandom, $urandom);
        drain();
        // asynchronous reset mid-drain with three entries queued
        step(1, 0, 32'h20, $urandom, 32'h20);
        step(1, 0, 32'h24, $urandom, 32'h20);
        step(1, 0, 32'h28, $urandom, 32'h20);
        reset = 1;
        #1;
        check("reset_wbuf_count", 32'(bus.wbuf_count), 32'h0);
        check("reset_mem_stall", 32'(bus.mem_stall), 32'h0);
        check("reset_overflow_err", 32'(bus.overflow_err), 32'h0);
        check("reset_array_word", bus.instr, commitMem[8]);
        pend.delete();
        schedValid = 0;
        ovfM = 0;
        for (int a = 0; a < WORDS; a++) viewMem[a] = commitMem[a];
        @(posedge clk);
        #1 reset = 0;
        // randomized traffic: light then heavy store load, wrapped and misaligned addresses
        for (int i = 0; i < 600; i++) begin
            logic [31:0] addr;
            addr = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            step($urandom_range(0, 99) < (i < 300 ? 15 : 60), $urandom_range(0, 1) == 1,
                 addr, $urandom, (32'($urandom_range(0, 7)) << 2));
        end
        drain();
        repeat (2) idle(32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
